conv_encoder_tx: RTL
====================

// Module: conv_encoder_tx
// PURPOSE
//  Rate-1/2 convolutional encoder; the transmit-side counterpart of the Viterbi decoder.
//  - Accepts one SIZE_DATA-bit word per frame.
//  - Shifts the word out MSB first and emits one 2-bit code symbol per input bit.
//  - Appends K-1 zero tail bits so the trellis terminates in state 0 for the decoder.
//  - Output symbols use a valid/ready handshake toward the channel/UART path.
// PARAMETERS
//  SIZE_DATA     8       payload bits per frame
//  SIZE_OUT      2       symbol width (fixed 2, rate 1/2)
//  CONSTRAINT_K  3       constraint length K; encoder memory = K-1 bits
//  G0            3'b111  generator for o_sym[1]; bit K-1 taps the current input bit
//  G1            3'b101  generator for o_sym[0]
// PORTS
//  i_clk        in   1          system clock, rising edge
//  i_rst_n      in   1          asynchronous active-low reset
//  i_start      in   1          start request; sampled only while o_busy=0
//  i_data       in   SIZE_DATA  payload word, captured on an accepted i_start
//  o_busy       out  1          frame in progress
//  o_sym        out  SIZE_OUT   code symbol {G0 parity, G1 parity}
//  o_sym_valid  out  1          o_sym holds a valid symbol
//  i_sym_ready  in   1          downstream accepts o_sym this cycle
//  o_done       out  1          1-cycle pulse after the last symbol is accepted
// BEHAVIOUR
//  Reset
//  - All outputs are 0 and the FSM is IDLE.
//  - Data shift register, encoder state s[K-2:0] and the symbol counter are cleared.
//  - Reset takes effect asynchronously, including mid-frame: o_sym_valid drops with no
//    completion and no o_done.
//  FSM states: IDLE, ENCODE, DONE
//  - IDLE -> ENCODE on i_start.
//    - Capture i_data, clear s, set count=0.
//    - Register the first symbol; o_sym_valid=1 and o_busy=1 in the next cycle
//      (latency 1 cycle).
//  - ENCODE: a handshake is o_sym_valid & i_sym_ready.
//    - On a handshake, s and the counter advance and the next symbol is registered in
//      the same edge, so back-to-back transfers run at 1 symbol/cycle.
//    - Without a handshake, o_sym, o_sym_valid and s hold stable.
//  - ENCODE -> DONE on the handshake of symbol index SIZE_DATA+K-2 (the last symbol).
//    - o_sym_valid=0 from then on.
//  - DONE lasts one cycle with o_done=1 and o_busy=0.
//    - i_start in DONE is accepted and goes straight to ENCODE.
//    - Otherwise the next state is IDLE.
//  Encoding per symbol
//  - b = current data bit, taken MSB first; b=0 for the K-1 tail symbols.
//  - reg = {b, s}.
//  - o_sym[1] = ^(reg & G0); o_sym[0] = ^(reg & G1).
//  - On each handshake: s <= {b, s[K-2:1]}.
//  - Frame length is exactly SIZE_DATA+K-1 symbols (10 at defaults).
//  - The counter is wide enough for SIZE_DATA+K-1 and never wraps inside a frame.
//  Boundary conditions
//  - i_start while o_busy=1 is ignored; i_data changes mid-frame have no effect.
//  - i_sym_ready high while o_sym_valid=0 has no effect.
//  - o_sym_valid never deasserts before its handshake.
//  - i_sym_ready held low stalls indefinitely with no loss.
//  - s is reset at each frame start, so frames are independent.
// TESTING
//  1. i_data=8'hB4, i_sym_ready=1 -> symbols 11,10,00,01,01,00,10,11,00,00 on 10
//     consecutive cycles, then one o_done pulse.
//  2. i_data=8'h80 (impulse) -> 11,10,11 followed by seven 00 symbols.
//  3. i_data=8'hB4 with i_sym_ready toggling 1 cycle on / 2 cycles off -> same symbol
//     sequence; o_sym stable throughout every stall.
//  4. i_start pulsed again mid-frame with i_data=8'hFF -> ignored; the 8'hB4 frame
//     completes unchanged.
//  5. i_rst_n driven low after the 4th symbol -> o_sym_valid=0 immediately and no
//     o_done; a new frame of 8'h00 then gives 10 symbols of 00.
//  6. i_start asserted in the DONE cycle with 8'h80 -> the next frame starts with
//     o_sym_valid on the following cycle; the output matches test 2.

Source files
------------

// File: rtl/conv_encoder_tx_if.sv
// ----------------------------------------------------------------------------
// conv_encoder_tx_if
//   Bundles the frame-control and symbol-stream signals of conv_encoder_tx.
//   Signal names keep the i_/o_ direction prefixes as seen from the encoder.
//
//   i_start      start request, sampled only while o_busy=0
//   i_data       payload word, captured on an accepted start
//   o_busy       frame in progress
//   o_sym        code symbol {G0 parity, G1 parity}
//   o_sym_valid  o_sym holds a valid symbol
//   i_sym_ready  downstream accepts o_sym this cycle
//   o_done       one-cycle pulse after the last symbol is accepted
//
//   modport slave  : the encoder
//   modport master : the frame source / symbol sink driving the encoder
// ----------------------------------------------------------------------------
interface conv_encoder_tx_if #(
   parameter int SIZE_DATA = 8,
   parameter int SIZE_OUT  = 2
);
   logic                 i_start;
   logic [SIZE_DATA-1:0] i_data;
   logic                 o_busy;
   logic [SIZE_OUT-1:0]  o_sym;
   logic                 o_sym_valid;
   logic                 i_sym_ready;
   logic                 o_done;

   modport slave (
      input  i_start,
      input  i_data,
      output o_busy,
      output o_sym,
      output o_sym_valid,
      input  i_sym_ready,
      output o_done
   );

   modport master (
      output i_start,
      output i_data,
      input  o_busy,
      input  o_sym,
      input  o_sym_valid,
      output i_sym_ready,
      input  o_done
   );
endinterface

// File: rtl/conv_encoder_tx.sv
// ----------------------------------------------------------------------------
// conv_encoder_tx
//   Rate-1/2 convolutional encoder for one SIZE_DATA-bit word per frame.
//   The word is shifted out MSB first, one 2-bit symbol per bit, followed by
//   K-1 zero tail bits so the trellis ends in state 0. Symbols leave through
//   a valid/ready handshake at up to one symbol per cycle.
//
//   Ports
//     i_clk    system clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      conv_encoder_tx_if.slave (start/data/busy/sym/valid/ready/done)
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for i_start, no symbol pending
//   ENCODE | symbol registered in o_sym, waiting for / taking handshakes
//   DONE   | one-cycle o_done pulse; i_start here starts the next frame
// ----------------------------------------------------------------------------
module conv_encoder_tx #(
   parameter int                      SIZE_DATA    = 8,
   parameter int                      SIZE_OUT     = 2,
   parameter int                      CONSTRAINT_K = 3,
   parameter logic [CONSTRAINT_K-1:0] G0           = 3'b111,
   parameter logic [CONSTRAINT_K-1:0] G1           = 3'b101
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   conv_encoder_tx_if.slave      bus
);

   localparam int N_SYM = SIZE_DATA + CONSTRAINT_K - 1;
   localparam int CNT_W = $clog2(N_SYM + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SYM - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENCODE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                  r_state;
   logic [SIZE_DATA-1:0]    r_data;
   logic [CONSTRAINT_K-2:0] r_s;
   logic [CNT_W-1:0]        r_cnt;
   logic [SIZE_OUT-1:0]     r_sym;
   logic                    r_sym_valid;
   logic                    r_busy;
   logic                    r_done;

   logic                    w_handshake;
   logic [CONSTRAINT_K-1:0] w_reg;
   logic [CONSTRAINT_K-2:0] w_s_next;
   logic [SIZE_DATA-1:0]    w_data_shift;
   logic [CONSTRAINT_K-1:0] w_reg_first;

   function automatic logic [SIZE_OUT-1:0] f_enc(input logic [CONSTRAINT_K-1:0] reg_v);
      return {^(reg_v & G0), ^(reg_v & G1)};
   endfunction

   assign w_handshake  = r_sym_valid & bus.i_sym_ready;

   // The data register shifts in zeros, so once the payload is exhausted its
   // MSB naturally supplies the K-1 tail bits.
   assign w_reg        = {r_data[SIZE_DATA-1], r_s};
   assign w_s_next     = w_reg[CONSTRAINT_K-1:1];
   assign w_data_shift = {r_data[SIZE_DATA-2:0], 1'b0};

   // First symbol of a frame: encoder state starts cleared.
   assign w_reg_first  = {bus.i_data[SIZE_DATA-1], {(CONSTRAINT_K-1){1'b0}}};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_data      <= '0;
         r_s         <= '0;
         r_cnt       <= '0;
         r_sym       <= '0;
         r_sym_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (bus.i_start) begin
                  r_state     <= ENCODE;
                  r_data      <= bus.i_data;
                  r_s         <= '0;
                  r_cnt       <= '0;
                  r_sym       <= f_enc(w_reg_first);
                  r_sym_valid <= 1'b1;
                  r_busy      <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            ENCODE: begin
               if (w_handshake) begin
                  r_s    <= w_s_next;
                  r_data <= w_data_shift;
                  r_cnt  <= r_cnt + 1'b1;
                  r_sym  <= f_enc({w_data_shift[SIZE_DATA-1], w_s_next});
                  if (r_cnt == LAST_IDX) begin
                     r_state     <= DONE;
                     r_sym_valid <= 1'b0;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_sym_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_busy      = r_busy;
   assign bus.o_sym       = r_sym;
   assign bus.o_sym_valid = r_sym_valid;
   assign bus.o_done      = r_done;

endmodule
